execute: RTL and testbench

- Execute (E) stage of the 5-stage RV32I pipeline; sits between decode and the memory stage.
- Contains the ID/EX pipeline register, the M/W forwarding muxes, the ALU, and branch/jump resolution.
- Adds an iterative 32-cycle multiplier for MUL (low word), which stalls the front end while it runs.
- Its _E outputs feed the memory stage directly.

---
 rtl/riscv_pkg.sv | 68 ++++++
 rtl/alu.sv | 40 ++++
 rtl/execute.sv | 177 +++++++++++++++++
 tb/tb_execute.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I execute stage.
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_CYCLES = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned CNT_W      = $clog2(MUL_CYCLES);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_W,
        FWD_M
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

    // ID/EX pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        alu_ctrl_t         alu_ctrl;
        logic              sel_alu_src;
        logic              rf_wr_en;
        logic              dm_wr_en;
        logic              sel_result;
        logic              branch;
        logic              jump;
        logic              mul;
    } idex_t;

    // Forwarding source for one operand; M is newer than W, x0 never forwarded
    function automatic fwd_sel_t fwd_select(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] addr_m,
        input logic              en_m,
        input logic [REG_AW-1:0] addr_w,
        input logic              en_w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (rs != '0 && en_w && addr_w == rs) sel = FWD_W;
        if (rs != '0 && en_m && addr_m == rs) sel = FWD_M;
        return sel;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU with zero flag.
module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      ctrl_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    localparam int unsigned SHW = $clog2(XLEN);

    alu_ctrl_t      ctrl;
    logic [SHW-1:0] shamt;

    assign ctrl  = alu_ctrl_t'(ctrl_i);
    assign shamt = b_i[SHW-1:0];

    // Operation select; unused codes give zero
    always_comb begin
        result_o = '0;
        case (ctrl)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLT:  result_o = XLEN'($signed(a_i) < $signed(b_i));
            ALU_SLTU: result_o = XLEN'(a_i < b_i);
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = XLEN'($signed(a_i) >>> shamt);
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/execute.sv
// Execute stage: ID/EX register, M/W forwarding, ALU, branch resolution and
// an iterative shift-add multiplier that stalls the front end.
module execute
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   i_rd_data_1_D,
    input  logic [XLEN-1:0]   i_rd_data_2_D,
    input  logic [XLEN-1:0]   i_imm_D,
    input  logic [XLEN-1:0]   i_PC_D,
    input  logic [REG_AW-1:0] i_rs1_addr_D,
    input  logic [REG_AW-1:0] i_rs2_addr_D,
    input  logic [REG_AW-1:0] i_rd_addr_D,
    input  logic [3:0]        i_ALU_ctrl_D,
    input  logic              i_sel_ALU_src_D,
    input  logic              i_register_file_wr_en_D,
    input  logic              i_data_memory_wr_en_D,
    input  logic              i_sel_result_D,
    input  logic              i_branch_D,
    input  logic              i_jump_D,
    input  logic              i_mul_D,
    input  logic              i_flush_E,
    input  logic [XLEN-1:0]   i_ALU_output_M,
    input  logic [REG_AW-1:0] i_register_file_wr_addr_M,
    input  logic              i_register_file_wr_en_M,
    input  logic [XLEN-1:0]   i_result_W,
    input  logic [REG_AW-1:0] i_register_file_wr_addr_W,
    input  logic              i_register_file_wr_en_W,
    output logic [XLEN-1:0]   o_ALU_output_E,
    output logic [XLEN-1:0]   o_wr_data_E,
    output logic [REG_AW-1:0] o_register_file_wr_addr_E,
    output logic              o_register_file_wr_en_E,
    output logic              o_data_memory_wr_en_E,
    output logic              o_sel_result_E,
    output logic [XLEN-1:0]   o_PC_target_E,
    output logic              o_PC_src_E,
    output logic [REG_AW-1:0] o_rs1_addr_E,
    output logic [REG_AW-1:0] o_rs2_addr_E,
    output logic              o_busy_E
);

    idex_t            idex_q, idex_d;
    mul_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  prod_q, prod_d;
    logic [XLEN-1:0]  mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;

    fwd_sel_t        fwd_a_sel, fwd_b_sel;
    logic [XLEN-1:0] op_a, rs2_fwd, op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            busy;

    assign fwd_a_sel = fwd_select(idex_q.rs1, i_register_file_wr_addr_M, i_register_file_wr_en_M,
                                  i_register_file_wr_addr_W, i_register_file_wr_en_W);
    assign fwd_b_sel = fwd_select(idex_q.rs2, i_register_file_wr_addr_M, i_register_file_wr_en_M,
                                  i_register_file_wr_addr_W, i_register_file_wr_en_W);

    // Operand forwarding muxes and operand-B source select
    always_comb begin
        case (fwd_a_sel)
            FWD_M:   op_a = i_ALU_output_M;
            FWD_W:   op_a = i_result_W;
            default: op_a = idex_q.rd1;
        endcase
        case (fwd_b_sel)
            FWD_M:   rs2_fwd = i_ALU_output_M;
            FWD_W:   rs2_fwd = i_result_W;
            default: rs2_fwd = idex_q.rd2;
        endcase
        op_b = idex_q.sel_alu_src ? idex_q.imm : rs2_fwd;
    end

    alu u_alu (
        .a_i      (op_a),
        .b_i      (op_b),
        .ctrl_i   (idex_q.alu_ctrl),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Stall is raised from the moment a MUL sits in E until its result is ready
    assign busy = (state_q == BUSY) || (state_q == IDLE && idex_q.mul);

    // ID/EX next value: flush beats hold beats load
    always_comb begin
        idex_d = idex_q;
        if (i_flush_E) begin
            idex_d = '0;
        end else if (!busy) begin
            idex_d.rd1         = i_rd_data_1_D;
            idex_d.rd2         = i_rd_data_2_D;
            idex_d.imm         = i_imm_D;
            idex_d.pc          = i_PC_D;
            idex_d.rs1         = i_rs1_addr_D;
            idex_d.rs2         = i_rs2_addr_D;
            idex_d.rd          = i_rd_addr_D;
            idex_d.alu_ctrl    = alu_ctrl_t'(i_ALU_ctrl_D);
            idex_d.sel_alu_src = i_sel_ALU_src_D;
            idex_d.rf_wr_en    = i_register_file_wr_en_D;
            idex_d.dm_wr_en    = i_data_memory_wr_en_D;
            idex_d.sel_result  = i_sel_result_D;
            idex_d.branch      = i_branch_D;
            idex_d.jump        = i_jump_D;
            idex_d.mul         = i_mul_D;
        end
    end

    // Multiplier FSM: capture forwarded operands, then shift-add one bit per cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        case (state_q)
            IDLE: begin
                if (idex_q.mul) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    prod_d   = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                end
            end
            BUSY: begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_CYCLES - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_flush_E) state_d = IDLE;
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q   <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            idex_q   <= idex_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Stage outputs; a stalled E presents a bubble to M and never redirects fetch
    always_comb begin
        if (state_q == DONE)  o_ALU_output_E = prod_q;
        else if (idex_q.jump) o_ALU_output_E = idex_q.pc + XLEN'(4);
        else                  o_ALU_output_E = alu_result;
        o_wr_data_E               = rs2_fwd;
        o_register_file_wr_addr_E = idex_q.rd;
        o_register_file_wr_en_E   = idex_q.rf_wr_en & ~busy;
        o_data_memory_wr_en_E     = idex_q.dm_wr_en & ~busy;
        o_sel_result_E            = idex_q.sel_result;
        o_PC_target_E             = idex_q.pc + idex_q.imm;
        o_PC_src_E                = ~busy & (idex_q.jump | (idex_q.branch & alu_zero));
        o_rs1_addr_E              = idex_q.rs1;
        o_rs2_addr_E              = idex_q.rs2;
        o_busy_E                  = busy;
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage against a behavioural model.
module tb_execute;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rd1, rd2, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  ctrl;
    logic        sel_src, rfw, dmw, selres, br, jmp, mul, flush;
    logic [31:0] alu_m, res_w;
    logic [4:0]  addr_m, addr_w;
    logic        en_m, en_w;

    logic [31:0] o_ALU_output_E, o_wr_data_E, o_PC_target_E;
    logic [4:0]  o_register_file_wr_addr_E, o_rs1_addr_E, o_rs2_addr_E;
    logic        o_register_file_wr_en_E, o_data_memory_wr_en_E, o_sel_result_E;
    logic        o_PC_src_E, o_busy_E;
    logic [115:0] all_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    execute dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .i_rd_data_1_D             (rd1),
        .i_rd_data_2_D             (rd2),
        .i_imm_D                   (imm),
        .i_PC_D                    (pc),
        .i_rs1_addr_D              (rs1),
        .i_rs2_addr_D              (rs2),
        .i_rd_addr_D               (rd),
        .i_ALU_ctrl_D              (ctrl),
        .i_sel_ALU_src_D           (sel_src),
        .i_register_file_wr_en_D   (rfw),
        .i_data_memory_wr_en_D     (dmw),
        .i_sel_result_D            (selres),
        .i_branch_D                (br),
        .i_jump_D                  (jmp),
        .i_mul_D                   (mul),
        .i_flush_E                 (flush),
        .i_ALU_output_M            (alu_m),
        .i_register_file_wr_addr_M (addr_m),
        .i_register_file_wr_en_M   (en_m),
        .i_result_W                (res_w),
        .i_register_file_wr_addr_W (addr_w),
        .i_register_file_wr_en_W   (en_w),
        .o_ALU_output_E            (o_ALU_output_E),
        .o_wr_data_E               (o_wr_data_E),
        .o_register_file_wr_addr_E (o_register_file_wr_addr_E),
        .o_register_file_wr_en_E   (o_register_file_wr_en_E),
        .o_data_memory_wr_en_E     (o_data_memory_wr_en_E),
        .o_sel_result_E            (o_sel_result_E),
        .o_PC_target_E             (o_PC_target_E),
        .o_PC_src_E                (o_PC_src_E),
        .o_rs1_addr_E              (o_rs1_addr_E),
        .o_rs2_addr_E              (o_rs2_addr_E),
        .o_busy_E                  (o_busy_E)
    );

    assign all_out = {o_ALU_output_E, o_wr_data_E, o_register_file_wr_addr_E,
                      o_register_file_wr_en_E, o_data_memory_wr_en_E, o_sel_result_E,
                      o_PC_target_E, o_PC_src_E, o_rs1_addr_E, o_rs2_addr_E, o_busy_E};

    // Reference ALU from the instruction-set definition
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a & b;
            3: return a | b;
            4: return a ^ b;
            5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6: return (a < b) ? 32'd1 : 32'd0;
            7: return a << sh;
            8: return a >> sh;
            9: return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Reference operand value seen by E given the current M/W writers
    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] regv);
        if (rs != 5'd0 && en_m && addr_m == rs) return alu_m;
        if (rs != 5'd0 && en_w && addr_w == rs) return res_w;
        return regv;
    endfunction

    task automatic set_d(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                         input logic s, input logic w, input logic dw, input logic sr,
                         input logic bb, input logic j, input logic m);
        ctrl = op; rd1 = a; rd2 = b; imm = im; pc = p;
        rs1 = r1; rs2 = r2; rd = rdd;
        sel_src = s; rfw = w; dmw = dw; selres = sr; br = bb; jmp = j; mul = m;
    endtask

    task automatic clear_mw();
        alu_m = 32'd0; addr_m = 5'd0; en_m = 1'b0;
        res_w = 32'd0; addr_w = 5'd0; en_w = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        clear_mw();
        set_d(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        checks++;
        if (all_out !== 116'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", all_out);
        end
        @(posedge clk); #2;
        checks++;
        if (all_out !== 116'd0) begin
            errors++; $display("FAIL reset_held got=%h exp=0", all_out);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        clear_mw();
        set_d(4'd0, 32'd5, 32'd7, 32'd0, 32'h10, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checks++;
        if (o_ALU_output_E !== 32'd12) begin
            errors++; $display("FAIL add_result got=%h exp=%h", o_ALU_output_E, 32'd12);
        end
        checks++;
        if ({o_register_file_wr_en_E, o_register_file_wr_addr_E} !== {1'b1, 5'd3}) begin
            errors++; $display("FAIL add_wr got=%b/%0d exp=1/3", o_register_file_wr_en_E, o_register_file_wr_addr_E);
        end
        checks++;
        if (o_busy_E !== 1'b0) begin
            errors++; $display("FAIL add_busy got=%b exp=0", o_busy_E);
        end
    endtask

    task automatic test_forwarding();
        set_d(4'd0, 32'hAAAA, 32'd1, 32'd0, 32'd0, 5'd3, 5'd4, 5'd5, 0, 1, 0, 0, 0, 0, 0);
        alu_m = 32'h100; addr_m = 5'd3; en_m = 1'b1;
        res_w = 32'h200; addr_w = 5'd3; en_w = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (o_ALU_output_E !== 32'h101) begin
            errors++; $display("FAIL fwd_m_priority got=%h exp=%h", o_ALU_output_E, 32'h101);
        end
        en_m = 1'b0; #1;
        checks++;
        if (o_ALU_output_E !== 32'h201) begin
            errors++; $display("FAIL fwd_w got=%h exp=%h", o_ALU_output_E, 32'h201);
        end
        set_d(4'd0, 32'h55, 32'd1, 32'd0, 32'd0, 5'd0, 5'd4, 5'd5, 0, 1, 0, 0, 0, 0, 0);
        alu_m = 32'h900; addr_m = 5'd0; en_m = 1'b1;
        res_w = 32'h700; addr_w = 5'd0; en_w = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (o_ALU_output_E !== 32'h56) begin
            errors++; $display("FAIL fwd_x0 got=%h exp=%h", o_ALU_output_E, 32'h56);
        end
        clear_mw();
    endtask

    task automatic test_branch();
        clear_mw();
        set_d(4'd1, 32'd9, 32'd9, 32'h10, 32'h40, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        checks++;
        if ({o_PC_src_E, o_PC_target_E} !== {1'b1, 32'h50}) begin
            errors++; $display("FAIL beq_taken got=%b/%h exp=1/%h", o_PC_src_E, o_PC_target_E, 32'h50);
        end
        set_d(4'd1, 32'd9, 32'd8, 32'h10, 32'h40, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #2;
        checks++;
        if (o_PC_src_E !== 1'b0) begin
            errors++; $display("FAIL beq_not_taken got=%b exp=0", o_PC_src_E);
        end
        set_d(4'd0, 32'd1, 32'd2, 32'h100, 32'h40, 5'd0, 5'd0, 5'd1, 1, 1, 0, 0, 0, 1, 0);
        @(posedge clk); #2;
        checks++;
        if ({o_PC_src_E, o_ALU_output_E, o_PC_target_E} !== {1'b1, 32'h44, 32'h140}) begin
            errors++; $display("FAIL jal got=%b/%h/%h exp=1/44/140", o_PC_src_E, o_ALU_output_E, o_PC_target_E);
        end
    endtask

    task automatic test_random_alu();
        logic [31:0] a, b, opb, r, exp_out;
        logic        exp_src;
        int          op;
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 15));
            set_d(4'(op), $urandom(), $urandom(), $urandom(), $urandom(),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            if (it % 4 == 0) rd2 = rd1;
            if (it % 8 == 1) rd2 = 32'd0;
            alu_m = $urandom(); addr_m = 5'($urandom_range(0, 3)); en_m = 1'($urandom_range(0, 1));
            res_w = $urandom(); addr_w = 5'($urandom_range(0, 3)); en_w = 1'($urandom_range(0, 1));
            a       = ref_fwd(rs1, rd1);
            b       = ref_fwd(rs2, rd2);
            opb     = sel_src ? imm : b;
            r       = ref_alu(op, a, opb);
            exp_out = jmp ? pc + 32'd4 : r;
            exp_src = jmp | (br & (r == 32'd0));
            @(posedge clk); #2;
            checks++;
            if (o_ALU_output_E !== exp_out) begin
                errors++; $display("FAIL rand_alu it=%0d op=%0d got=%h exp=%h", it, op, o_ALU_output_E, exp_out);
            end
            checks++;
            if (o_wr_data_E !== b) begin
                errors++; $display("FAIL rand_wr_data it=%0d got=%h exp=%h", it, o_wr_data_E, b);
            end
            checks++;
            if ({o_PC_src_E, o_PC_target_E} !== {exp_src, pc + imm}) begin
                errors++; $display("FAIL rand_branch it=%0d got=%b/%h exp=%b/%h", it, o_PC_src_E, o_PC_target_E, exp_src, pc + imm);
            end
            checks++;
            if ({o_register_file_wr_en_E, o_data_memory_wr_en_E, o_sel_result_E, o_register_file_wr_addr_E,
                 o_rs1_addr_E, o_rs2_addr_E} !== {rfw, dmw, selres, rd, rs1, rs2}) begin
                errors++; $display("FAIL rand_ctrl it=%0d got=%b%b%b/%0d/%0d/%0d", it, o_register_file_wr_en_E,
                                   o_data_memory_wr_en_E, o_sel_result_E, o_register_file_wr_addr_E, o_rs1_addr_E, o_rs2_addr_E);
            end
        end
        clear_mw();
    endtask

    task automatic test_mul();
        logic [31:0] a, b, exp;
        int          n;
        for (int k = 0; k < 4; k++) begin
            a   = (k == 0) ? 32'hFFFF_FFFF : $urandom();
            b   = (k == 0) ? 32'd3 : $urandom();
            exp = a * b;
            // rs2 arrives through W forwarding at capture time
            set_d(4'd0, a, 32'hDEAD_0000, 32'd0, 32'h100, 5'd5, 5'd6, 5'd7, 0, 1, 0, 0, 0, 0, 1);
            clear_mw();
            res_w = b; addr_w = 5'd6; en_w = 1'b1;
            @(posedge clk); #2;
            n = 0;
            while (o_busy_E === 1'b1 && n < 40) begin
                checks++;
                if ({o_register_file_wr_en_E, o_data_memory_wr_en_E, o_PC_src_E} !== 3'b000) begin
                    errors++; $display("FAIL mul_bubble k=%0d cyc=%0d got=%b%b%b exp=000", k, n,
                                       o_register_file_wr_en_E, o_data_memory_wr_en_E, o_PC_src_E);
                end
                n++;
                @(posedge clk); #2;
                if (n == 1) begin
                    res_w = ~b; alu_m = 32'h1234_5678; addr_m = 5'd5; en_m = 1'b1;
                    set_d(4'd0, 32'(k + 1), 32'd10, 32'd0, 32'h200, 5'd8, 5'd9, 5'd2, 0, 1, 0, 0, 0, 0, 0);
                end
            end
            checks++;
            if (n !== 33) begin
                errors++; $display("FAIL mul_busy_cycles k=%0d got=%0d exp=33", k, n);
            end
            checks++;
            if (o_ALU_output_E !== exp) begin
                errors++; $display("FAIL mul_result k=%0d got=%h exp=%h", k, o_ALU_output_E, exp);
            end
            checks++;
            if ({o_register_file_wr_en_E, o_register_file_wr_addr_E} !== {1'b1, 5'd7}) begin
                errors++; $display("FAIL mul_done_wr k=%0d got=%b/%0d exp=1/7", k, o_register_file_wr_en_E, o_register_file_wr_addr_E);
            end
            @(posedge clk); #2;
            checks++;
            if ({o_busy_E, o_ALU_output_E} !== {1'b0, 32'(k + 11)}) begin
                errors++; $display("FAIL mul_next_instr k=%0d got=%b/%h exp=0/%h", k, o_busy_E, o_ALU_output_E, 32'(k + 11));
            end
        end
        clear_mw();
    endtask

    task automatic test_flush();
        clear_mw();
        set_d(4'd0, 32'd7, 32'd9, 32'd0, 32'h300, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 0, 0, 1);
        @(posedge clk); #2;
        repeat (5) begin @(posedge clk); #2; end
        checks++;
        if (o_busy_E !== 1'b1) begin
            errors++; $display("FAIL flush_pre_busy got=%b exp=1", o_busy_E);
        end
        flush = 1'b1;
        set_d(4'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        flush = 1'b0;
        checks++;
        if ({o_busy_E, o_register_file_wr_en_E, o_data_memory_wr_en_E, o_sel_result_E, o_PC_src_E,
             o_register_file_wr_addr_E, o_rs1_addr_E, o_rs2_addr_E} !== 20'd0) begin
            errors++; $display("FAIL flush_ctrl got=%b%b%b%b%b/%0d/%0d/%0d exp=0", o_busy_E, o_register_file_wr_en_E,
                               o_data_memory_wr_en_E, o_sel_result_E, o_PC_src_E, o_register_file_wr_addr_E,
                               o_rs1_addr_E, o_rs2_addr_E);
        end
        set_d(4'd2, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        checks++;
        if ({o_busy_E, o_ALU_output_E} !== {1'b0, 32'h00F0}) begin
            errors++; $display("FAIL flush_resume got=%b/%h exp=0/%h", o_busy_E, o_ALU_output_E, 32'h00F0);
        end
    endtask

    task automatic test_async_reset();
        clear_mw();
        set_d(4'd0, 32'd11, 32'd13, 32'h4, 32'h400, 5'd1, 5'd2, 5'd3, 0, 1, 1, 1, 0, 0, 1);
        @(posedge clk); #2;
        repeat (4) begin @(posedge clk); #2; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (all_out !== 116'd0) begin
            errors++; $display("FAIL async_reset got=%h exp=0", all_out);
        end
        set_d(4'd0, 32'd20, 32'd22, 32'd0, 32'd0, 5'd1, 5'd2, 5'd4, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #2;
        checks++;
        if ({o_busy_E, o_ALU_output_E, o_register_file_wr_en_E} !== {1'b0, 32'd42, 1'b1}) begin
            errors++; $display("FAIL post_reset_add got=%b/%h/%b exp=0/%h/1", o_busy_E, o_ALU_output_E,
                               o_register_file_wr_en_E, 32'd42);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_forwarding();
        test_branch();
        test_random_alu();
        test_mul();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
